// File: rtl/alu_rf_sequencer_pkg.sv
// Shared definitions for the ALU/register-file micro-sequencer.
//   - opcode encodings (OP_ADD..OP_LOADI)
//   - FSM state encoding
//   - instruction field offsets for instr = {op, rd, rs1, rs2}
//   - op_writes(): whether an opcode commits a result
// Optional feature macro: SEQ_LOADI_EN (op F becomes a load-immediate).
package alu_rf_sequencer_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD   = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB   = 4'h1;
  localparam logic [OP_W-1:0] OP_AND   = 4'h2;
  localparam logic [OP_W-1:0] OP_OR    = 4'h3;
  localparam logic [OP_W-1:0] OP_XOR   = 4'h4;
  localparam logic [OP_W-1:0] OP_NOT   = 4'h5;
  localparam logic [OP_W-1:0] OP_SHL   = 4'h6;
  localparam logic [OP_W-1:0] OP_SHR   = 4'h7;
  localparam logic [OP_W-1:0] OP_MOV   = 4'h8;
  localparam logic [OP_W-1:0] OP_INC   = 4'h9;
  localparam logic [OP_W-1:0] OP_DEC   = 4'hA;
  localparam logic [OP_W-1:0] OP_LOADI = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  // Field LSB positions as a function of the register address width.
  function automatic int rs2_lsb(input int aw); return 0;      endfunction
  function automatic int rs1_lsb(input int aw); return aw;     endfunction
  function automatic int rd_lsb (input int aw); return 2 * aw; endfunction
  function automatic int op_lsb (input int aw); return 3 * aw; endfunction

  // Opcodes B..E (and F without the immediate feature) retire as NOPs.
  function automatic logic op_writes(input logic [OP_W-1:0] op);
`ifdef SEQ_LOADI_EN
    return (op <= OP_DEC) || (op == OP_LOADI);
`else
    return (op <= OP_DEC);
`endif
  endfunction

endpackage

// File: rtl/alu_rf_sequencer_alu_8b.sv
// Combinational ALU for the sequencer.
// Ports:
//   op  in  [3:0]        opcode
//   a   in  [DATA_W-1:0] operand A (rs1, or the immediate for LOADI)
//   b   in  [DATA_W-1:0] operand B (rs2)
//   cy  out [DATA_W:0]   {carry/borrow, result}
// Optional feature macro: SEQ_LOADI_EN (op F passes a through, C=0).
module alu_8b
  import alu_rf_sequencer_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W:0]   cy
);

  logic [DATA_W:0] a_x, b_x;
  assign a_x = {1'b0, a};
  assign b_x = {1'b0, b};

  // The extra top bit of the widened add/sub is carry out or borrow out.
  always_comb begin
    cy = '0;
    case (op)
      OP_ADD: cy = a_x + b_x;
      OP_SUB: cy = a_x - b_x;
      OP_AND: cy = {1'b0, a & b};
      OP_OR:  cy = {1'b0, a | b};
      OP_XOR: cy = {1'b0, a ^ b};
      OP_NOT: cy = {1'b0, ~a};
      OP_SHL: cy = {a, 1'b0};
      OP_SHR: cy = {a[0], 1'b0, a[DATA_W-1:1]};
      OP_MOV: cy = a_x;
      OP_INC: cy = a_x + (DATA_W+1)'(1);
      OP_DEC: cy = a_x - (DATA_W+1)'(1);
`ifdef SEQ_LOADI_EN
      OP_LOADI: cy = a_x;
`endif
      default: cy = '0;
    endcase
  end

endmodule

// File: rtl/alu_rf_sequencer.sv
// Single-issue micro-sequencer in front of a 2R1W register file.
// Accepts {op, rd, rs1, rs2} on a valid/ready handshake, reads the two
// operands, executes them in alu_8b and writes the result back.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   instr_valid/ready/instr instruction handshake
//   rf_raddr1/2, rf_rdata1/2 register-file read ports (combinational data)
//   rf_waddr/wdata/we       register-file write port
//   done                    one-cycle retire pulse
//   result, flag_z, flag_c  last retired result and flags
// Optional feature macro: SEQ_LOADI_EN (op F = load {rs1,rs2} into rd,
// skipping READ; requires DATA_W == 2*ADDR_W).
module alu_rf_sequencer
  import alu_rf_sequencer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [4+3*ADDR_W-1:0] instr,
  output logic [ADDR_W-1:0]     rf_raddr1,
  output logic [ADDR_W-1:0]     rf_raddr2,
  input  logic [DATA_W-1:0]     rf_rdata1,
  input  logic [DATA_W-1:0]     rf_rdata2,
  output logic [ADDR_W-1:0]     rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  rf_we,
  output logic                  done,
  output logic [DATA_W-1:0]     result,
  output logic                  flag_z,
  output logic                  flag_c
);

  localparam int RS2_LSB = rs2_lsb(ADDR_W);
  localparam int RS1_LSB = rs1_lsb(ADDR_W);
  localparam int RD_LSB  = rd_lsb(ADDR_W);
  localparam int OP_LSB  = op_lsb(ADDR_W);

`ifdef SEQ_LOADI_EN
  generate
    if (DATA_W != 2 * ADDR_W) begin : g_loadi_width_err
      $error("SEQ_LOADI_EN requires DATA_W == 2*ADDR_W");
    end
  endgenerate
`endif

  state_t state, nstate;

  logic [OP_W-1:0]   op_q;
  logic [ADDR_W-1:0] rd_q, rs1_q, rs2_q;
  logic [DATA_W-1:0] op_a, op_b, result_q;
  logic              z_q, c_q;

  logic [OP_W-1:0]   in_op;
  logic [ADDR_W-1:0] in_rd, in_rs1, in_rs2;
  logic              accept;
  logic [DATA_W:0]   alu_cy;

  assign in_op  = instr[OP_LSB  +: OP_W];
  assign in_rd  = instr[RD_LSB  +: ADDR_W];
  assign in_rs1 = instr[RS1_LSB +: ADDR_W];
  assign in_rs2 = instr[RS2_LSB +: ADDR_W];

  // Gating with rst_n keeps every output low while reset is held.
  assign instr_ready = (state == S_IDLE) && rst_n;
  assign accept      = instr_ready && instr_valid;

  alu_8b #(.DATA_W(DATA_W)) u_alu (
    .op (op_q),
    .a  (op_a),
    .b  (op_b),
    .cy (alu_cy)
  );

  always_comb begin
    nstate = state;
    rf_we  = 1'b0;
    done   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
`ifdef SEQ_LOADI_EN
          nstate = (in_op == OP_LOADI) ? S_EXEC : S_READ;
`else
          nstate = S_READ;
`endif
        end
      end
      S_READ:  nstate = S_EXEC;
      S_EXEC:  nstate = S_WRITE;
      S_WRITE: begin
        nstate = S_IDLE;
        rf_we  = op_writes(op_q);
        done   = 1'b1;
      end
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      op_a     <= '0;
      op_b     <= '0;
      result_q <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
    end else begin
      state <= nstate;
      if (accept) begin
        op_q  <= in_op;
        rd_q  <= in_rd;
        rs1_q <= in_rs1;
        rs2_q <= in_rs2;
`ifdef SEQ_LOADI_EN
        // The immediate rides through the ALU as operand A.
        if (in_op == OP_LOADI) op_a <= DATA_W'({in_rs1, in_rs2});
`endif
      end
      if (state == S_READ) begin
        op_a <= rf_rdata1;
        op_b <= rf_rdata2;
      end
      if (state == S_EXEC && op_writes(op_q)) begin
        result_q <= alu_cy[DATA_W-1:0];
        c_q      <= alu_cy[DATA_W];
        z_q      <= (alu_cy[DATA_W-1:0] == '0);
      end
    end
  end

  // Addresses come straight from the instruction latch, so they hold
  // steady through READ/EXEC/WRITE and read 0 after reset.
  assign rf_raddr1 = rs1_q;
  assign rf_raddr2 = rs2_q;
  assign rf_waddr  = rd_q;
  assign rf_wdata  = result_q;
  assign result    = result_q;
  assign flag_z    = z_q;
  assign flag_c    = c_q;

endmodule

// File: tb/tb_alu_rf_sequencer.sv
module tb_alu_rf_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [3:0]  rf_raddr1, rf_raddr2, rf_waddr;
  logic [7:0]  rf_rdata1, rf_rdata2, rf_wdata, result;
  logic        rf_we, done, flag_z, flag_c;

  always #5 clk = ~clk;

  alu_rf_sequencer #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_we(rf_we),
    .done(done), .result(result), .flag_z(flag_z), .flag_c(flag_c)
  );

  // Register file: combinational reads, synchronous write, no reset.
  logic [7:0] rf [16];
  always @(posedge clk) if (rf_we) rf[rf_waddr] <= rf_wdata;
  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: architectural registers and flags.
  int mregs [16];
  int mres;
  bit mz, mc;

`ifdef SEQ_LOADI_EN
  localparam bit LOADI = 1'b1;
`else
  localparam bit LOADI = 1'b0;
`endif

  function automatic bit mexec(input int op, input int rd, input int rs1, input int rs2);
    int a, b, y;
    bit c, w;
    a = mregs[rs1]; b = mregs[rs2]; y = 0; c = 0; w = 1;
    case (op)
      0:  begin y = a + b; c = (y > 255); end
      1:  begin y = a - b; c = (a < b); end
      2:  y = a & b;
      3:  y = a | b;
      4:  y = a ^ b;
      5:  y = 255 - a;
      6:  begin y = a * 2; c = (a >= 128); end
      7:  begin y = a / 2; c = (a % 2 == 1); end
      8:  y = a;
      9:  begin y = a + 1; c = (a == 255); end
      10: begin y = a - 1; c = (a == 0); end
      15: if (LOADI) y = rs1 * 16 + rs2; else w = 0;
      default: w = 0;
    endcase
    y = ((y % 256) + 256) % 256;
    if (w) begin
      mregs[rd] = y; mres = y; mz = (y == 0); mc = c;
    end
    return w;
  endfunction

  typedef struct {
    logic [3:0] op, rd, rs1, rs2;
    bit         wr;
    logic [7:0] y;
    bit         c, z;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] op, rd, rs1, rs2,
                              input bit wr, input logic [7:0] y, input bit c, z);
    vec_t v;
    v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.wr = wr; v.y = y; v.c = c; v.z = z;
    return v;
  endfunction

  // Issue one instruction, follow it to retirement and check everything.
  task automatic do_instr(input logic [3:0] op, rd, rs1, rs2, input bit tab,
                          input vec_t v);
    bit w, we_early;
    int n, k, lat;
    w   = mexec(op, rd, rs1, rs2);
    lat = (LOADI && op == 4'hF) ? 1 : 2;
    @(negedge clk);
    n = 0;
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin chk("ready_timeout", 0, 1); return; end
    instr_valid = 1'b1;
    instr = {op, rd, rs1, rs2};
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    k = 0; we_early = 0;
    while (!done && k < 8) begin
      if (rf_we) we_early = 1;
      @(negedge clk); k++;
    end
    chk("latency", k, lat);
    chk("we_before_done", we_early, 0);
    chk("rf_we", rf_we, w);
    if (w) begin
      chk("rf_waddr", rf_waddr, rd);
      chk("rf_wdata", rf_wdata, mres);
    end
    @(negedge clk);
    chk("done_width", done, 0);
    chk("rf_rd", rf[rd], mregs[rd]);
    chk("result", result, mres);
    chk("flag_z", flag_z, mz);
    chk("flag_c", flag_c, mc);
    if (tab) begin
      chk("tab_wr", w, v.wr);
      chk("tab_y", result, v.y);
      chk("tab_c", flag_c, v.c);
      chk("tab_z", flag_z, v.z);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab [$];
    vec_t dummy;
    logic [15:0] q [3];
    int acc [3];
    int idx, dn, rdyc;
    bit rdy, w, we_seen;

    dummy = mk(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin rf[i] = 8'h00; mregs[i] = 0; end
    rf[0] = 8'h01; mregs[0] = 1;
    rf[1] = 8'h80; mregs[1] = 128;
    rf[2] = 8'h81; mregs[2] = 129;
    mres = 0; mz = 0; mc = 0;

    // Hand-computed directed vectors (starting R0=01 R1=80 R2=81).
    tab.push_back(mk(4'h0, 3, 1, 2, 1, 8'h01, 1, 0));   // ADD
    tab.push_back(mk(4'h1, 4, 1, 1, 1, 8'h00, 0, 1));   // SUB to zero
    tab.push_back(mk(4'hA, 5, 4, 0, 1, 8'hFF, 1, 0));   // DEC 0
    tab.push_back(mk(4'h6, 0, 0, 0, 1, 8'h02, 0, 0));   // walking one
    tab.push_back(mk(4'h6, 0, 0, 0, 1, 8'h04, 0, 0));
    tab.push_back(mk(4'h6, 0, 0, 0, 1, 8'h08, 0, 0));
    tab.push_back(mk(4'h6, 0, 0, 0, 1, 8'h10, 0, 0));
    tab.push_back(mk(4'h6, 0, 0, 0, 1, 8'h20, 0, 0));
    tab.push_back(mk(4'h6, 0, 0, 0, 1, 8'h40, 0, 0));
    tab.push_back(mk(4'h6, 0, 0, 0, 1, 8'h80, 0, 0));
    tab.push_back(mk(4'h6, 0, 0, 0, 1, 8'h00, 1, 1));
    tab.push_back(mk(4'h2, 6, 1, 2, 1, 8'h80, 0, 0));   // AND
    tab.push_back(mk(4'h3, 7, 3, 2, 1, 8'h81, 0, 0));   // OR
    tab.push_back(mk(4'h4, 8, 1, 2, 1, 8'h01, 0, 0));   // XOR
    tab.push_back(mk(4'h5, 9, 4, 0, 1, 8'hFF, 0, 0));   // NOT
    tab.push_back(mk(4'h7, 10, 2, 0, 1, 8'h40, 1, 0));  // SHR
    tab.push_back(mk(4'h8, 11, 5, 0, 1, 8'hFF, 0, 0));  // MOV
    tab.push_back(mk(4'h9, 12, 5, 0, 1, 8'h00, 1, 1));  // INC FF
    tab.push_back(mk(4'h1, 13, 4, 3, 1, 8'hFF, 1, 0));  // SUB borrow
    tab.push_back(mk(4'h0, 14, 14, 14, 1, 8'h00, 0, 1)); // rd==rs1==rs2
    tab.push_back(mk(4'hB, 15, 1, 2, 0, 8'h00, 0, 1));  // NOP keeps flags
    if (LOADI) tab.push_back(mk(4'hF, 6, 3, 4'hC, 1, 8'h3C, 0, 0));
    else       tab.push_back(mk(4'hF, 6, 3, 4'hC, 0, 8'h00, 0, 1));

    // Reset state
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", instr_ready, 0);
    chk("rst_we_done", {rf_we, done}, 0);
    chk("rst_addrs", {rf_raddr1, rf_raddr2, rf_waddr}, 0);
    chk("rst_data", {rf_wdata, result, flag_z, flag_c}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", instr_ready, 1);

    foreach (tab[i]) do_instr(tab[i].op, tab[i].rd, tab[i].rs1, tab[i].rs2, 1, tab[i]);

    // Valid held high with three queued instructions.
    q[0] = {4'h9, 4'd1, 4'd1, 4'd0};
    q[1] = {4'h9, 4'd1, 4'd1, 4'd0};
    q[2] = {4'h0, 4'd2, 4'd1, 4'd1};
    idx = 0; dn = 0; rdyc = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      if (done) dn++;
      instr_valid = (idx < 3);
      instr = q[(idx < 3) ? idx : 2];
      rdy = instr_ready;
      if (rdy && cyc < 12) rdyc++;
      @(posedge clk);
      if (rdy && idx < 3) begin acc[idx] = cyc; idx++; end
    end
    instr_valid = 1'b0;
    chk("hold_accepts", idx, 3);
    chk("hold_gap1", acc[1] - acc[0], 4);
    chk("hold_gap2", acc[2] - acc[1], 4);
    chk("hold_ready_cycles", rdyc, 3);
    chk("hold_dones", dn, 3);
    w = mexec(9, 1, 1, 0);
    w = mexec(9, 1, 1, 0);
    w = mexec(0, 2, 1, 1);
    chk("hold_r1", rf[1], mregs[1]);
    chk("hold_r2", rf[2], 8'h04);
    chk("hold_c", flag_c, 1);

    // Reset during EXEC of ADD R7
    @(negedge clk);
    instr_valid = 1'b1;
    instr = {4'h0, 4'd7, 4'd1, 4'd2};
    @(posedge clk);
    @(negedge clk);  // READ
    instr_valid = 1'b0;
    @(negedge clk);  // EXEC
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_we_done", {rf_we, done}, 0);
    chk("midrst_ready", instr_ready, 0);
    chk("midrst_outs", {rf_raddr1, rf_raddr2, rf_waddr, rf_wdata, result, flag_z, flag_c}, 0);
    rst_n = 1'b1;
    mres = 0; mz = 0; mc = 0;
    we_seen = 0;
    @(negedge clk);
    chk("midrst_ready_after", instr_ready, 1);
    repeat (4) begin if (rf_we) we_seen = 1; @(negedge clk); end
    chk("midrst_no_write", we_seen, 0);
    chk("midrst_r7", rf[7], mregs[7]);

    // Randomized instructions against the model
    for (int i = 0; i < 40; i++)
      do_instr(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 0, dummy);

    for (int i = 0; i < 16; i++) chk($sformatf("final_r%0d", i), rf[i], mregs[i]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/alu_rf_sequencer.md
Name: alu_rf_sequencer

Overview:
- Single-issue micro-sequencer that sits in front of the 8-bit, 16-entry register file (two combinational read ports, one synchronous write port).
- Accepts one instruction at a time over a valid/ready handshake and drives both read addresses.
- Latches the operands, executes them in an internal 8-bit ALU, and writes the result back through the register-file write port.
- Produces the register-file stimulus that drives the register file in the ALU/register-file datapath.

Parameters:
- DATA_W, 8: operand/result width; matches the register-file data width.
- ADDR_W, 4: register address width; gives 16 registers.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  sequencer can accept an instruction.
- instr  in  4+3*ADDR_W  {op[3:0], rd, rs1, rs2}; 16 bits at defaults.
- rf_raddr1  out  ADDR_W  register-file read address 1 (rs1).
- rf_raddr2  out  ADDR_W  register-file read address 2 (rs2).
- rf_rdata1  in  DATA_W  register-file read data 1 (combinational).
- rf_rdata2  in  DATA_W  register-file read data 2 (combinational).
- rf_waddr  out  ADDR_W  write address (rd).
- rf_wdata  out  DATA_W  write data.
- rf_we  out  1  write enable.
- done  out  1  one-cycle pulse when an instruction retires.
- result  out  DATA_W  last retired result, held between instructions.
- flag_z  out  1  zero flag.
- flag_c  out  1  carry/borrow flag.

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE; all outputs 0; instruction latch 0. A reset mid-operation aborts the instruction, and rf_we is 0 in the cycle after reset, so no write occurs. The register file itself has no reset.
- FSM states: IDLE -> READ -> EXEC -> WRITE -> IDLE.
  - IDLE: instr_ready=1. If instr_valid, latch instr and go to READ; otherwise stay.
  - READ: rf_raddr1/2 = latched rs1/rs2. At the end of the cycle, latch rf_rdata1/2 into opA/opB.
  - EXEC: compute from opA/opB; register the result and next flags.
  - WRITE: rf_we=1 (except NOP), rf_waddr=rd, rf_wdata=result, done=1.
- rf_raddr1/2 and rf_waddr are held at the latched fields in every non-IDLE state.
- Timing: instruction accepted on edge N; write commits on edge N+3; done is high during the cycle before edge N+3. Throughput is 1 instruction per 4 cycles.
- instr_ready is 0 outside IDLE. A valid instruction presented then is ignored and must be held by the producer.
- Because operations are serialized, a following instruction always reads the freshly written value. rd==rs1==rs2 is legal.
- Opcodes (mod 2^DATA_W arithmetic):
  - 0 ADD a+b, C=carry out.
  - 1 SUB a-b, C=borrow (a<b).
  - 2 AND; 3 OR; 4 XOR; 5 NOT a; C=0 for all four.
  - 6 SHL a by 1, C=a[MSB].
  - 7 SHR a by 1 (logical), C=a[0].
  - 8 MOV a, C=0.
  - 9 INC a, C=carry (a==all-ones).
  - A DEC a, C=borrow (a==0).
  - B-E NOP.
  - F LOADI (see Optional Feature), otherwise NOP.
- Flags: Z=(result==0). Flags and result update only for writing ops. NOP still walks through all states and pulses done, but keeps rf_we=0 and leaves flags/result unchanged.

Optional Feature:
- Macro: SEQ_LOADI_EN.
- Defined: op F writes rd <= {rs1,rs2} as an immediate; READ is skipped (IDLE -> EXEC), so latency is 2 edges; Z updated, C=0. Requires DATA_W==2*ADDR_W, checked with an elaboration-time error.
- Undefined: op F is a NOP with the normal 4-cycle path.

Decomposition:
- Shared package holds:
  - opcode localparams (OP_ADD..OP_LOADI);
  - state encoding (IDLE=0, READ=1, EXEC=2, WRITE=3);
  - instruction field offsets.
- One natural sub-module, alu_8b: combinational, takes (op, a, b) and returns {c, y}. The sequencer owns all registers.

Test Plan (SEQ_LOADI_EN defined unless stated; sequencer drives the real register file):
1. LOADI R1=0x80, LOADI R2=0x81, ADD R3=R1+R2 -> R3=0x01, flag_c=1, flag_z=0. ADD write lands 3 edges after acceptance; done pulses exactly once.
2. SUB R4=R1-R1 -> 0x00, flag_z=1, flag_c=0. Then DEC R5=R4 -> 0xFF, flag_c=1.
3. Walking one: LOADI R0=0x01, then SHL R0=R0 eight times -> R0 goes 0x02..0x80 then 0x00, with C=1 on the last shift. Proves back-to-back read-after-write.
4. Hold instr_valid=1 continuously with 3 queued instructions -> instr_ready high only in IDLE; each accepted exactly once, 4 cycles apart.
5. Assert rst_n=0 during EXEC of ADD R7=... -> no rf_we pulse, R7 unchanged, all outputs 0 next cycle, instr_ready=1 after release.
6. SEQ_LOADI_EN undefined: op F to R6 -> rf_we stays 0, done pulses, R6 and flags unchanged.
